// File: rtl/trig_capture_pkg.sv
// Shared types and constants for the trigger-capture block.
// The HDR state exists only when TRIG_CAPTURE_HEADER_EN is defined.
package trig_capture_pkg;

    localparam int SAMPLE_W = 14;
    localparam logic [7:0] HDR_B0 = 8'hA5;
    localparam logic [7:0] HDR_B1 = 8'h5A;

`ifdef TRIG_CAPTURE_HEADER_EN
    typedef enum logic [2:0] {
        S_IDLE, S_PREFILL, S_ARMED, S_POST, S_HDR, S_SEND
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_PREFILL, S_ARMED, S_POST, S_SEND
    } state_t;
`endif

endpackage

// File: rtl/trig_capture_ram.sv
// Simple dual-port sample buffer, one write port and one registered read port.
module trig_capture_ram
    import trig_capture_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [SAMPLE_W-1:0] wdata,
    input  logic [AW-1:0]       raddr,
    output logic [SAMPLE_W-1:0] rdata
);

    logic [SAMPLE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/trig_capture.sv
// Pre/post-trigger ADC capture into a circular buffer, streamed out as bytes.
// Define TRIG_CAPTURE_HEADER_EN to prefix each record with A5 5A rec_count[7:0].
module trig_capture
    import trig_capture_pkg::*;
#(
    parameter int DEPTH    = 256,
    parameter int PRE_TRIG = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SAMPLE_W-1:0] adc_in,
    input  logic                trig_in,
    input  logic                arm,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                armed,
    output logic                busy,
    output logic [15:0]         rec_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] ONE       = AW'(1);
    localparam logic [AW-1:0] PRE_OFS   = AW'(PRE_TRIG);
    localparam logic [AW-1:0] PRE_LAST  = AW'(PRE_TRIG - 1);
    localparam logic [AW-1:0] POST_LAST = AW'(DEPTH - PRE_TRIG - 2);
    localparam logic [AW-1:0] SEND_LAST = AW'(DEPTH - 1);

    state_t              state;
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       cnt;
    logic [AW-1:0]       start;
    logic [AW-1:0]       rd_ptr;
    logic [AW-1:0]       sent;
    logic                low_next;
    logic [7:0]          cur_low;
    logic                we;
    logic [SAMPLE_W-1:0] rdata;
`ifdef TRIG_CAPTURE_HEADER_EN
    logic [1:0]          hdr_idx;
`endif

    assign we = (state == S_PREFILL) || (state == S_ARMED) || (state == S_POST);

    trig_capture_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr),
        .wdata (adc_in),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    // rd_ptr always addresses the next sample to load, so rdata is already
    // valid when the low byte of the current sample is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            wr_ptr    <= '0;
            cnt       <= '0;
            start     <= '0;
            rd_ptr    <= '0;
            sent      <= '0;
            low_next  <= 1'b0;
            tx_valid  <= 1'b0;
            tx_data   <= '0;
            armed     <= 1'b0;
            busy      <= 1'b0;
            rec_count <= '0;
`ifdef TRIG_CAPTURE_HEADER_EN
            hdr_idx   <= '0;
`endif
        end else begin
            if (we)
                wr_ptr <= wr_ptr + ONE;
            case (state)
                S_IDLE: begin
                    if (arm) begin
                        state  <= S_PREFILL;
                        busy   <= 1'b1;
                        wr_ptr <= '0;
                        cnt    <= '0;
                    end
                end
                S_PREFILL: begin
                    cnt <= cnt + ONE;
                    if (cnt == PRE_LAST) begin
                        state <= S_ARMED;
                        armed <= 1'b1;
                    end
                end
                S_ARMED: begin
                    if (trig_in) begin
                        start  <= wr_ptr - PRE_OFS;
                        rd_ptr <= wr_ptr - PRE_OFS;
                        cnt    <= '0;
                        armed  <= 1'b0;
                        state  <= S_POST;
                    end
                end
                S_POST: begin
                    cnt <= cnt + ONE;
                    if (cnt == POST_LAST) begin
                        sent     <= '0;
                        low_next <= 1'b0;
`ifdef TRIG_CAPTURE_HEADER_EN
                        state    <= S_HDR;
                        tx_data  <= HDR_B0;
                        tx_valid <= 1'b1;
                        hdr_idx  <= '0;
`else
                        state    <= S_SEND;
`endif
                    end
                end
`ifdef TRIG_CAPTURE_HEADER_EN
                S_HDR: begin
                    if (tx_ready) begin
                        hdr_idx <= hdr_idx + 2'd1;
                        case (hdr_idx)
                            2'd0:    tx_data <= HDR_B1;
                            2'd1:    tx_data <= rec_count[7:0];
                            default: begin
                                state    <= S_SEND;
                                tx_data  <= {2'b00, rdata[13:8]};
                                cur_low  <= rdata[7:0];
                                low_next <= 1'b1;
                                rd_ptr   <= rd_ptr + ONE;
                            end
                        endcase
                    end
                end
`endif
                S_SEND: begin
                    if (!tx_valid) begin
                        tx_valid <= 1'b1;
                        tx_data  <= {2'b00, rdata[13:8]};
                        cur_low  <= rdata[7:0];
                        low_next <= 1'b1;
                        rd_ptr   <= rd_ptr + ONE;
                    end else if (tx_ready) begin
                        if (low_next) begin
                            tx_data  <= cur_low;
                            low_next <= 1'b0;
                        end else if (sent == SEND_LAST) begin
                            tx_valid  <= 1'b0;
                            busy      <= 1'b0;
                            rec_count <= rec_count + 16'd1;
                            state     <= S_IDLE;
                        end else begin
                            tx_data  <= {2'b00, rdata[13:8]};
                            cur_low  <= rdata[7:0];
                            low_next <= 1'b1;
                            rd_ptr   <= rd_ptr + ONE;
                            sent     <= sent + ONE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    logic unused_start;
    assign unused_start = ^start;

endmodule

// File: tb/tb_trig_capture.sv
// Scoreboard bench for trig_capture: a ramp ADC, randomized triggers and tx_ready,
// expected bytes derived from the ramp value at the trigger.
module tb_trig_capture;

    localparam int DEPTH    = 16;
    localparam int PRE_TRIG = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [13:0] adc_in;
    logic        trig_in;
    logic        arm;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        armed;
    logic        busy;
    logic [15:0] rec_count;

    always #5 clk = ~clk;

    trig_capture #(.DEPTH(DEPTH), .PRE_TRIG(PRE_TRIG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .adc_in    (adc_in),
        .trig_in   (trig_in),
        .arm       (arm),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .armed     (armed),
        .busy      (busy),
        .rec_count (rec_count)
    );

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];
    int ramp = 0;
    int rdy_mode = 0;
    int pat_i = 0;
    int exp_recs = 0;
    int bytes_seen = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted byte, checks hold under backpressure.
    logic       pv = 1'b0;
    logic       pr = 1'b0;
    logic [7:0] pd = 8'h00;
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (pv && !pr) begin
                check("hold_valid", int'(tx_valid), 1);
                check("hold_data", int'(tx_data), int'(pd));
            end
            if (tx_valid && tx_ready) begin
                bytes_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got 0x%0h, expected no byte", tx_data);
                end else begin
                    check("byte", int'(tx_data), int'(exp_q.pop_front()));
                end
            end
            pv = tx_valid;
            pr = tx_ready;
            pd = tx_data;
        end else begin
            pv = 1'b0;
            pr = 1'b0;
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
        ramp++;
        adc_in = 14'(ramp);
        pat_i++;
        case (rdy_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = (pat_i % 4 == 0) || (pat_i % 4 == 3);
            default: tx_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    // Record = ramp values tv-PRE_TRIG .. tv+DEPTH-PRE_TRIG-1, high byte then low byte.
    task automatic push_record(input int tv);
        logic [13:0] s;
`ifdef TRIG_CAPTURE_HEADER_EN
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'(exp_recs));
`endif
        for (int i = 0; i < DEPTH; i++) begin
            s = 14'(tv - PRE_TRIG + i);
            exp_q.push_back({2'b00, s[13:8]});
            exp_q.push_back(s[7:0]);
        end
    endtask

    task automatic run_capture(input int tv, input int mode, input bit early,
                               input bit late, input int abort_after);
        int base;
        int budget;
        rdy_mode = mode;
        pat_i = 0;
        base = bytes_seen;
        arm = 1'b1;
        cycle();
        arm = 1'b0;
        ramp = 0;
        adc_in = 14'd0;
        check("busy_after_arm", int'(busy), 1);
        while (ramp <= tv + 4) begin
            trig_in = (ramp == tv) || (early && ramp == 1) || (late && ramp == tv + 3);
            if (early && ramp == 1)
                check("armed_in_prefill", int'(armed), 0);
            if (ramp == tv) begin
                check("armed_at_trigger", int'(armed), 1);
                push_record(tv);
            end
            if (ramp == tv + 1)
                check("armed_in_post", int'(armed), 0);
            cycle();
        end
        trig_in = 1'b0;
        budget = 0;
        while (busy && budget < 3000) begin
            if (abort_after > 0 && bytes_seen - base >= abort_after)
                break;
            arm = (budget == 5);
            cycle();
            arm = 1'b0;
            budget++;
        end
        if (abort_after > 0) begin
            rst_n = 1'b0;
            tx_ready = 1'b0;
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            check("abort_tx_valid", int'(tx_valid), 0);
            check("abort_busy", int'(busy), 0);
            check("abort_rec_count", int'(rec_count), 0);
            exp_q.delete();
            exp_recs = 0;
        end else begin
            if (busy) begin
                checks++;
                errors++;
                $display("FAIL record_timeout: busy still 1 after %0d cycles, expected 0", budget);
            end
            exp_recs++;
            check("rec_count", int'(rec_count), exp_recs);
            check("queue_drained", exp_q.size(), 0);
            check("idle_tx_valid", int'(tx_valid), 0);
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        arm = 1'b0;
        trig_in = 1'b0;
        tx_ready = 1'b0;
        adc_in = 14'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_tx_valid", int'(tx_valid), 0);
        check("rst_tx_data", int'(tx_data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_armed", int'(armed), 0);
        check("rst_rec_count", int'(rec_count), 0);
        rst_n = 1'b1;

        trig_in = 1'b1;
        cycle();
        trig_in = 1'b0;
        cycle();
        check("idle_trig_ignored", int'(busy), 0);

        run_capture(20, 0, 1'b0, 1'b0, 0);
        run_capture(20, 1, 1'b0, 1'b0, 0);
        run_capture(23, 0, 1'b1, 1'b1, 0);
        run_capture(13, 0, 1'b0, 1'b0, 0);
        run_capture(20, 0, 1'b0, 1'b0, 7);
        run_capture(20, 0, 1'b0, 1'b0, 0);
        run_capture(20, 0, 1'b0, 1'b0, 0);
        for (int r = 0; r < 6; r++)
            run_capture(int'($urandom_range(4, 40)), 2, 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
